// File: rtl/int_div_arb_if.sv
// int_div_arb_if: request, response and divider-side signals of the two-port divider arbiter.
interface int_div_arb_if #(parameter int W = 64);
  logic flush;
  logic [1:0] req_valid;
  logic [1:0] req_ready;
  logic [1:0] req_unsigned;
  logic [1:0] req_residual;
  logic [1:0] req_rv32;
  logic [1:0][W-1:0] req_a1;
  logic [1:0][W-1:0] req_a2;
  logic [1:0] resp_valid;
  logic [1:0][W-1:0] resp_res;
  logic [1:0] resp_err;
  logic div_ena;
  logic div_unsigned;
  logic div_residual;
  logic div_rv32;
  logic [W-1:0] div_a1;
  logic [W-1:0] div_a2;
  logic div_busy;
  logic div_valid;
  logic [W-1:0] div_res;
  modport slave(
    input flush, req_valid, req_unsigned, req_residual, req_rv32, req_a1, req_a2, div_busy, div_valid, div_res,
    output req_ready, resp_valid, resp_res, resp_err, div_ena, div_unsigned, div_residual, div_rv32, div_a1, div_a2
  );
  modport master(
    output flush, req_valid, req_unsigned, req_residual, req_rv32, req_a1, req_a2, div_busy, div_valid, div_res,
    input req_ready, resp_valid, resp_res, resp_err, div_ena, div_unsigned, div_residual, div_rv32, div_a1, div_a2
  );
endinterface

// File: rtl/int_div_arb.sv
// int_div_arb: round-robin two-port sequencer for the shared divider with timeout; optional result cache via INT_DIV_ARB_CACHE_EN.
module int_div_arb #(
  parameter int RISCV_ARCH = 64,
  parameter int TIMEOUT = 64
) (
  input logic i_clk,
  input logic i_rst,
  int_div_arb_if.slave b
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  state_t state, state_n;
  logic ptr, owner, gnt, accept, hit, err, expire;
  logic [RISCV_ARCH-1:0] res, hit_res;
  logic [7:0] timer;
`ifdef INT_DIV_ARB_CACHE_EN
  logic c_valid, c_unsigned, c_residual, c_rv32;
  logic [RISCV_ARCH-1:0] c_a1, c_a2, c_res;
  always_comb begin
    hit = c_valid && c_a1 == b.req_a1[gnt] && c_a2 == b.req_a2[gnt] && c_unsigned == b.req_unsigned[gnt]
      && c_residual == b.req_residual[gnt] && c_rv32 == b.req_rv32[gnt];
    hit_res = c_res;
  end
  // A flush in the same cycle as a divider result leaves the entry invalid.
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) begin
      c_valid <= 1'b0;
      c_unsigned <= 1'b0;
      c_residual <= 1'b0;
      c_rv32 <= 1'b0;
      c_a1 <= '0;
      c_a2 <= '0;
      c_res <= '0;
    end else begin
      c_valid <= !b.flush && (c_valid || (state == WAIT && b.div_valid));
      if (state == WAIT && b.div_valid) begin
        c_unsigned <= b.div_unsigned;
        c_residual <= b.div_residual;
        c_rv32 <= b.div_rv32;
        c_a1 <= b.div_a1;
        c_a2 <= b.div_a2;
        c_res <= b.div_res;
      end
    end
`else
  logic unused_flush;
  assign unused_flush = b.flush;
  assign hit = 1'b0;
  assign hit_res = '0;
`endif
  always_comb begin
    gnt = &b.req_valid ? ptr : b.req_valid[1];
    accept = state == IDLE && |b.req_valid && !i_rst;
    b.req_ready = {gnt, ~gnt} & {2{accept}};
    b.div_ena = state == ISSUE && !b.div_busy;
    expire = timer == 8'(TIMEOUT - 2);
    b.resp_valid = {owner, ~owner} & {2{state == RESP}};
    b.resp_err = b.resp_valid & {2{err}};
    b.resp_res[0] = b.resp_valid[0] ? res : {RISCV_ARCH{1'b0}};
    b.resp_res[1] = b.resp_valid[1] ? res : {RISCV_ARCH{1'b0}};
    state_n = state;
    case (state)
      IDLE: state_n = accept ? (hit ? RESP : ISSUE) : IDLE;
      ISSUE: state_n = b.div_busy ? ISSUE : WAIT;
      WAIT: state_n = (b.div_valid || expire) ? RESP : WAIT;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) begin
      state <= IDLE;
      ptr <= 1'b0;
      owner <= 1'b0;
      timer <= '0;
      res <= '0;
      err <= 1'b0;
      b.div_unsigned <= 1'b0;
      b.div_residual <= 1'b0;
      b.div_rv32 <= 1'b0;
      b.div_a1 <= '0;
      b.div_a2 <= '0;
    end else begin
      state <= state_n;
      if (accept) begin
        owner <= gnt;
        b.div_unsigned <= b.req_unsigned[gnt];
        b.div_residual <= b.req_residual[gnt];
        b.div_rv32 <= b.req_rv32[gnt];
        b.div_a1 <= b.req_a1[gnt];
        b.div_a2 <= b.req_a2[gnt];
        res <= hit_res;
        err <= 1'b0;
      end
      if (b.div_ena)
        timer <= '0;
      else if (state == WAIT)
        timer <= timer + 8'd1;
      // A result arriving on the expiry cycle is still taken as good.
      if (state == WAIT && b.div_valid) begin
        res <= b.div_res;
        err <= 1'b0;
      end else if (state == WAIT && expire) begin
        res <= '0;
        err <= 1'b1;
      end
      if (state == RESP)
        ptr <= ~owner;
    end
endmodule
